// File: rtl/router_lookup_pkg.sv
// Shared types and constants for the output-port-lookup stage and the
// destination-IP table arbiter.
package router_lookup_pkg;

   localparam int TBL_ADDR_WIDTH = 5;
   localparam int TBL_DEPTH      = 1 << TBL_ADDR_WIDTH;

   // Who owns the table RAM in a given cycle; registered, it selects the response.
   typedef enum logic [1:0] {
      G_IDLE = 2'd0,
      G_LKP  = 2'd1,
      G_RD   = 2'd2,
      G_WR   = 2'd3
   } gstate_t;

   // Arbitration order, highest first.
   localparam int PRIO_CPU_STARVED = 0;
   localparam int PRIO_LOOKUP      = 1;
   localparam int PRIO_CPU_WRITE   = 2;
   localparam int PRIO_CPU_READ    = 3;

   // When the CPU side wins, a pending write always goes before a pending read.
   function automatic gstate_t cpu_pick(input logic wr_pending);
      return wr_pending ? G_WR : G_RD;
   endfunction

endpackage

// File: rtl/dest_ip_table_arbiter_if.sv
// Lookup, CPU register and table-RAM signals of the destination-IP table
// arbiter; slave is the arbiter's view, master the surrounding blocks' view.
interface dest_ip_table_arbiter_if #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int TBL_ADDR_WIDTH     = router_lookup_pkg::TBL_ADDR_WIDTH
);

   logic                          lkp_req;
   logic [TBL_ADDR_WIDTH-1:0]     lkp_addr;
   logic                          lkp_gnt;
   logic [C_S_AXI_DATA_WIDTH-1:0] lkp_data;
   logic                          lkp_vld;

   logic                          tbl_rd_req;
   logic [TBL_ADDR_WIDTH-1:0]     tbl_rd_addr;
   logic [C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data;
   logic                          tbl_rd_ack;
   logic                          tbl_wr_req;
   logic [TBL_ADDR_WIDTH-1:0]     tbl_wr_addr;
   logic [C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data;
   logic                          tbl_wr_ack;

   logic                          mem_en;
   logic                          mem_we;
   logic [TBL_ADDR_WIDTH-1:0]     mem_addr;
   logic [C_S_AXI_DATA_WIDTH-1:0] mem_wdata;
   logic [C_S_AXI_DATA_WIDTH-1:0] mem_rdata;

   modport slave (
      input  lkp_req, lkp_addr,
      output lkp_gnt, lkp_data, lkp_vld,
      input  tbl_rd_req, tbl_rd_addr, tbl_wr_req, tbl_wr_addr, tbl_wr_data,
      output tbl_rd_data, tbl_rd_ack, tbl_wr_ack,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output lkp_req, lkp_addr,
      input  lkp_gnt, lkp_data, lkp_vld,
      output tbl_rd_req, tbl_rd_addr, tbl_wr_req, tbl_wr_addr, tbl_wr_data,
      input  tbl_rd_data, tbl_rd_ack, tbl_wr_ack,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/dest_ip_table_arbiter.sv
// Shares the single-port destination-IP table RAM between datapath lookups and
// CPU register reads/writes. Statistics counters exist only with DEST_IP_TBL_ARB_STATS_EN.
module dest_ip_table_arbiter
   import router_lookup_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int TBL_ADDR_WIDTH     = router_lookup_pkg::TBL_ADDR_WIDTH,
   parameter int CPU_MAX_WAIT       = 4
) (
   input  logic                    AXI_ACLK,
   input  logic                    AXI_RESETN,
   dest_ip_table_arbiter_if.slave  bus,
   input  logic                    clear_counters,
   output logic [31:0]             cpu_wait_count,
   output logic [31:0]             cpu_overrun_count
);

   localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

   gstate_t                       grant;
   gstate_t                       gstate;
   logic                          cpu_gnt;

   logic                          rd_pend;
   logic [TBL_ADDR_WIDTH-1:0]     rd_pend_addr;
   logic                          wr_pend;
   logic [TBL_ADDR_WIDTH-1:0]     wr_pend_addr;
   logic [C_S_AXI_DATA_WIDTH-1:0] wr_pend_data;
   logic [3:0]                    wait_ctr;
   logic [C_S_AXI_DATA_WIDTH-1:0] rd_hold;

   logic                          cpu_pend;
   logic                          starved;

   assign cpu_pend = rd_pend | wr_pend;
   assign starved  = cpu_pend && (wait_ctr == MAX_WAIT);
   assign cpu_gnt  = (grant == G_RD) || (grant == G_WR);

   // Grant decision. Only registered pending requests compete, so a CPU pulse
   // is eligible the cycle after it is captured. Reset idles the RAM at once.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      grant = G_IDLE;
      if (!AXI_RESETN)      grant = G_IDLE;
      else if (starved)     grant = cpu_pick(wr_pend);
      else if (bus.lkp_req) grant = G_LKP;
      else if (wr_pend)     grant = G_WR;
      else if (rd_pend)     grant = G_RD;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
      if (!AXI_RESETN) gstate <= G_IDLE;
      else             gstate <= grant;
   end

   always_comb begin
      bus.lkp_gnt   = (grant == G_LKP);
      bus.mem_en    = (grant != G_IDLE);
      bus.mem_we    = (grant == G_WR);
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      unique case (grant)
         G_LKP: bus.mem_addr = bus.lkp_addr;
         G_RD:  bus.mem_addr = rd_pend_addr;
         G_WR: begin
            bus.mem_addr  = wr_pend_addr;
            bus.mem_wdata = wr_pend_data;
         end
         default: ;
      endcase
   end

   // Responses follow last cycle's grant; read data is visible in the ack
   // cycle and held afterwards until the next read ack.
   always_comb begin
      bus.lkp_vld     = (gstate == G_LKP);
      bus.tbl_rd_ack  = (gstate == G_RD);
      bus.tbl_wr_ack  = (gstate == G_WR);
      bus.lkp_data    = bus.lkp_vld ? bus.mem_rdata : '0;
      bus.tbl_rd_data = bus.tbl_rd_ack ? bus.mem_rdata : rd_hold;
   end

   always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
      if (!AXI_RESETN)         rd_hold <= '0;
      else if (gstate == G_RD) rd_hold <= bus.mem_rdata;
   end

   // Pending CPU registers: a pulse is dropped while its register is occupied.
   always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
      if (!AXI_RESETN) begin
         rd_pend      <= 1'b0;
         rd_pend_addr <= '0;
         wr_pend      <= 1'b0;
         wr_pend_addr <= '0;
         wr_pend_data <= '0;
      end else begin
         if (grant == G_RD) begin
            rd_pend <= 1'b0;
         end else if (bus.tbl_rd_req && !rd_pend) begin
            rd_pend      <= 1'b1;
            rd_pend_addr <= bus.tbl_rd_addr;
         end
         if (grant == G_WR) begin
            wr_pend <= 1'b0;
         end else if (bus.tbl_wr_req && !wr_pend) begin
            wr_pend      <= 1'b1;
            wr_pend_addr <= bus.tbl_wr_addr;
            wr_pend_data <= bus.tbl_wr_data;
         end
      end
   end

   // Consecutive lookup wins against a waiting CPU access.
   always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
      if (!AXI_RESETN) begin
         wait_ctr <= '0;
      end else if (cpu_gnt) begin
         wait_ctr <= '0;
      end else if (cpu_pend && (grant == G_LKP) && (wait_ctr != MAX_WAIT)) begin
         wait_ctr <= wait_ctr + 4'd1;
      end
   end

`ifdef DEST_IP_TBL_ARB_STATS_EN
   logic [31:0] wait_cnt;
   logic [31:0] overrun_cnt;
   logic        rd_overrun;
   logic        wr_overrun;

   assign rd_overrun = bus.tbl_rd_req && rd_pend;
   assign wr_overrun = bus.tbl_wr_req && wr_pend;

   always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
      if (!AXI_RESETN) begin
         wait_cnt    <= '0;
         overrun_cnt <= '0;
      end else if (clear_counters) begin
         wait_cnt    <= '0;
         overrun_cnt <= '0;
      end else begin
         if (cpu_pend && !cpu_gnt) wait_cnt <= wait_cnt + 32'd1;
         overrun_cnt <= overrun_cnt + 32'(rd_overrun) + 32'(wr_overrun);
      end
   end

   assign cpu_wait_count    = wait_cnt;
   assign cpu_overrun_count = overrun_cnt;
`else
   logic unused_clear;
   assign unused_clear      = clear_counters;
   assign cpu_wait_count    = '0;
   assign cpu_overrun_count = '0;
`endif

endmodule

// File: tb/tb_dest_ip_table_arbiter.sv
// Self-checking bench for dest_ip_table_arbiter: directed scenarios plus random
// traffic against a cycle-level reference model and a behavioural table RAM.
module tb_dest_ip_table_arbiter;

   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int MAXW = 4;
`ifdef DEST_IP_TBL_ARB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear_counters;
   logic [31:0] cpu_wait_count;
   logic [31:0] cpu_overrun_count;

   int n_checks = 0;
   int n_pass   = 0;

   dest_ip_table_arbiter_if #(.C_S_AXI_DATA_WIDTH(DW), .TBL_ADDR_WIDTH(AW)) bus ();

   dest_ip_table_arbiter #(
      .C_S_AXI_DATA_WIDTH(DW),
      .TBL_ADDR_WIDTH(AW),
      .CPU_MAX_WAIT(MAXW)
   ) dut (
      .AXI_ACLK(clk),
      .AXI_RESETN(rst_n),
      .bus(bus),
      .clear_counters(clear_counters),
      .cpu_wait_count(cpu_wait_count),
      .cpu_overrun_count(cpu_overrun_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input int a);
      logic [31:0] v;
      v = {8'hC0, 8'(a), 16'hBEEF};
      if (a == 3) v = 32'h0A000001;
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      else n_pass++;
   endtask

   // Behavioural single-port RAM, one-cycle read latency.
   logic [31:0] ram [32];
   logic        ram_init = 1'b0;
   always @(posedge clk) begin
      if (!ram_init) begin
         for (int i = 0; i < 32; i++) ram[i] <= init_val(i);
         ram_init <= 1'b1;
      end else if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata    <= ram[bus.mem_addr];
      end
   end

   // Reference model: table contents, pending CPU accesses, lost-round count,
   // last cycle's winner and the counters, all updated once per cycle.
   logic [31:0] m_tbl [32];
   logic        m_init = 1'b0;
   logic        m_rd_pend, m_wr_pend;
   logic [4:0]  m_rd_addr, m_wr_addr;
   logic [31:0] m_wr_data;
   int          m_starve;
   logic        m_last_lkp, m_last_rd, m_last_wr;
   logic [31:0] m_last_lkp_val, m_last_rd_val, m_rd_hold;
   logic [31:0] m_wait, m_ovr;

   always @(negedge clk) begin : model
      logic       any_pend, starved, lkp_win, cpu_turn, wr_turn, rd_turn, exp_en;
      logic [4:0] exp_addr;
      if (!m_init) begin
         for (int i = 0; i < 32; i++) m_tbl[i] <= init_val(i);
         m_init <= 1'b1;
      end
      if (!rst_n) begin
         m_rd_pend <= 1'b0; m_wr_pend <= 1'b0; m_rd_addr <= '0; m_wr_addr <= '0;
         m_wr_data <= '0; m_starve <= 0; m_last_lkp <= 1'b0; m_last_rd <= 1'b0;
         m_last_wr <= 1'b0; m_last_lkp_val <= '0; m_last_rd_val <= '0;
         m_rd_hold <= '0; m_wait <= '0; m_ovr <= '0;
      end else begin
         any_pend = m_rd_pend || m_wr_pend;
         starved  = any_pend && (m_starve == MAXW);
         lkp_win  = bus.lkp_req && !starved;
         cpu_turn = any_pend && !lkp_win;
         wr_turn  = cpu_turn && m_wr_pend;
         rd_turn  = cpu_turn && !m_wr_pend;
         exp_en   = lkp_win || cpu_turn;
         exp_addr = lkp_win ? bus.lkp_addr : (wr_turn ? m_wr_addr : m_rd_addr);

         check("m_lkp_gnt", bus.lkp_gnt, lkp_win);
         check("m_mem_en", bus.mem_en, exp_en);
         check("m_mem_we", bus.mem_we, wr_turn);
         if (exp_en)  check("m_mem_addr", bus.mem_addr, exp_addr);
         if (wr_turn) check("m_mem_wdata", bus.mem_wdata, m_wr_data);
         check("m_lkp_vld", bus.lkp_vld, m_last_lkp);
         if (m_last_lkp) check("m_lkp_data", bus.lkp_data, m_last_lkp_val);
         check("m_rd_ack", bus.tbl_rd_ack, m_last_rd);
         check("m_wr_ack", bus.tbl_wr_ack, m_last_wr);
         check("m_rd_data", bus.tbl_rd_data, m_last_rd ? m_last_rd_val : m_rd_hold);
         check("m_wait_cnt", cpu_wait_count, m_wait);
         check("m_ovr_cnt", cpu_overrun_count, m_ovr);

         if (m_last_rd) m_rd_hold <= m_last_rd_val;
         m_last_lkp     <= lkp_win;
         m_last_lkp_val <= m_tbl[bus.lkp_addr];
         m_last_rd      <= rd_turn;
         m_last_rd_val  <= m_tbl[m_rd_addr];
         m_last_wr      <= wr_turn;
         if (wr_turn) m_tbl[m_wr_addr] <= m_wr_data;

         if (rd_turn) m_rd_pend <= 1'b0;
         else if (bus.tbl_rd_req && !m_rd_pend) begin
            m_rd_pend <= 1'b1; m_rd_addr <= bus.tbl_rd_addr;
         end
         if (wr_turn) m_wr_pend <= 1'b0;
         else if (bus.tbl_wr_req && !m_wr_pend) begin
            m_wr_pend <= 1'b1; m_wr_addr <= bus.tbl_wr_addr; m_wr_data <= bus.tbl_wr_data;
         end

         if (cpu_turn) m_starve <= 0;
         else if (any_pend && lkp_win && m_starve < MAXW) m_starve <= m_starve + 1;

         if (STATS) begin
            if (clear_counters) begin
               m_wait <= '0; m_ovr <= '0;
            end else begin
               if (any_pend && !cpu_turn) m_wait <= m_wait + 32'd1;
               m_ovr <= m_ovr + 32'(bus.tbl_rd_req && m_rd_pend) + 32'(bus.tbl_wr_req && m_wr_pend);
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic pulse_clear();
      next_cycle();
      clear_counters = 1'b1;
      next_cycle();
      clear_counters = 1'b0;
   endtask

   initial begin
      int   acks;
      logic [31:0] got;
      logic prev_gnt;

      bus.lkp_req = 1'b0; bus.lkp_addr = '0;
      bus.tbl_rd_req = 1'b0; bus.tbl_rd_addr = '0;
      bus.tbl_wr_req = 1'b0; bus.tbl_wr_addr = '0; bus.tbl_wr_data = '0;
      clear_counters = 1'b0;

      // Reset values while reset is held
      repeat (2) @(posedge clk);
      sample();
      check("rst_mem_en", bus.mem_en, 1'b0);
      check("rst_lkp_vld", bus.lkp_vld, 1'b0);
      check("rst_rd_ack", bus.tbl_rd_ack, 1'b0);
      check("rst_wr_ack", bus.tbl_wr_ack, 1'b0);
      check("rst_rd_data", bus.tbl_rd_data, 32'h0);
      check("rst_wait_cnt", cpu_wait_count, 32'h0);
      check("rst_ovr_cnt", cpu_overrun_count, 32'h0);
      next_cycle();
      rst_n = 1'b1;

      // Idle lookup of address 3
      next_cycle();
      bus.lkp_req = 1'b1; bus.lkp_addr = 5'd3;
      sample();
      check("lkp_gnt_same_cycle", bus.lkp_gnt, 1'b1);
      next_cycle();
      bus.lkp_req = 1'b0;
      sample();
      check("lkp_vld_next", bus.lkp_vld, 1'b1);
      check("lkp_data_addr3", bus.lkp_data, 32'h0A000001);

      // CPU write then read of address 7
      next_cycle();
      bus.tbl_wr_req = 1'b1; bus.tbl_wr_addr = 5'd7; bus.tbl_wr_data = 32'hC0A80101;
      next_cycle();
      bus.tbl_wr_req = 1'b0;
      sample();
      check("wr_grant_we", bus.mem_we, 1'b1);
      check("wr_grant_addr", bus.mem_addr, 32'd7);
      next_cycle();
      sample();
      check("wr_ack_plus2", bus.tbl_wr_ack, 1'b1);
      next_cycle();
      bus.tbl_rd_req = 1'b1; bus.tbl_rd_addr = 5'd7;
      next_cycle();
      bus.tbl_rd_req = 1'b0;
      next_cycle();
      sample();
      check("rd_ack_plus2", bus.tbl_rd_ack, 1'b1);
      check("rd_data_written", bus.tbl_rd_data, 32'hC0A80101);

      // Starvation: continuous lookups, CPU read forced through after MAXW losses
      pulse_clear();
      bus.lkp_req = 1'b1; bus.lkp_addr = 5'd1;
      bus.tbl_rd_req = 1'b1; bus.tbl_rd_addr = 5'd5;
      for (int c = 1; c <= MAXW; c++) begin
         next_cycle();
         bus.tbl_rd_req = 1'b0;
         sample();
         check("starve_lkp_wins", bus.lkp_gnt, 1'b1);
      end
      next_cycle();
      sample();
      check("starve_cpu_gnt", bus.lkp_gnt, 1'b0);
      check("starve_cpu_addr", bus.mem_addr, 32'd5);
      check("starve_cpu_we", bus.mem_we, 1'b0);
      next_cycle();
      bus.lkp_req = 1'b0;
      sample();
      check("starve_rd_ack", bus.tbl_rd_ack, 1'b1);
      check("starve_rd_data", bus.tbl_rd_data, init_val(5));
      check("starve_wait_cnt", cpu_wait_count, STATS ? 32'd4 : 32'd0);

      // Simultaneous CPU read and write pulses
      next_cycle();
      bus.tbl_wr_req = 1'b1; bus.tbl_wr_addr = 5'd9; bus.tbl_wr_data = 32'h0A0B0C0D;
      bus.tbl_rd_req = 1'b1; bus.tbl_rd_addr = 5'd9;
      next_cycle();
      bus.tbl_wr_req = 1'b0; bus.tbl_rd_req = 1'b0;
      sample();
      check("both_write_first", bus.mem_we, 1'b1);
      next_cycle();
      sample();
      check("both_wr_ack", bus.tbl_wr_ack, 1'b1);
      check("both_no_rd_ack", bus.tbl_rd_ack, 1'b0);
      next_cycle();
      sample();
      check("both_rd_ack", bus.tbl_rd_ack, 1'b1);
      check("both_rd_data", bus.tbl_rd_data, 32'h0A0B0C0D);

      // Overrun: second read pulse while the first is still pending
      pulse_clear();
      bus.lkp_req = 1'b1; bus.lkp_addr = 5'd0;
      bus.tbl_rd_req = 1'b1; bus.tbl_rd_addr = 5'd2;
      next_cycle();
      bus.tbl_rd_addr = 5'd4;
      next_cycle();
      bus.tbl_rd_req = 1'b0; bus.lkp_req = 1'b0;
      acks = 0; got = '0;
      for (int c = 0; c < 8; c++) begin
         sample();
         if (bus.tbl_rd_ack) begin
            acks++;
            got = bus.tbl_rd_data;
         end
         next_cycle();
      end
      check("ovr_one_ack", 32'(acks), 32'd1);
      check("ovr_first_addr", got, init_val(2));
      check("ovr_count", cpu_overrun_count, STATS ? 32'd1 : 32'd0);

      // Reset asserted the cycle after a write pulse
      bus.tbl_wr_req = 1'b1; bus.tbl_wr_addr = 5'd11; bus.tbl_wr_data = 32'hDEADBEEF;
      next_cycle();
      bus.tbl_wr_req = 1'b0;
      #1 rst_n = 1'b0;
      sample();
      check("rstmid_mem_en", bus.mem_en, 1'b0);
      check("rstmid_wr_ack", bus.tbl_wr_ack, 1'b0);
      check("rstmid_rd_data", bus.tbl_rd_data, 32'h0);
      check("rstmid_ovr_cnt", cpu_overrun_count, 32'h0);
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      acks = 0;
      for (int c = 0; c < 5; c++) begin
         sample();
         if (bus.tbl_wr_ack) acks++;
         next_cycle();
      end
      check("rstmid_no_ack", 32'(acks), 32'd0);
      bus.lkp_req = 1'b1; bus.lkp_addr = 5'd11;
      next_cycle();
      bus.lkp_req = 1'b0;
      sample();
      check("rstmid_unwritten", bus.lkp_data, init_val(11));

      // Random traffic; a lookup request is held with its address until granted
      prev_gnt = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         next_cycle();
         if (!(bus.lkp_req && !prev_gnt)) begin
            bus.lkp_req  = ($urandom_range(0, 4) < 3);
            bus.lkp_addr = 5'($urandom);
         end
         bus.tbl_rd_req  = ($urandom_range(0, 4) == 0);
         bus.tbl_rd_addr = 5'($urandom);
         bus.tbl_wr_req  = ($urandom_range(0, 5) == 0);
         bus.tbl_wr_addr = 5'($urandom);
         bus.tbl_wr_data = $urandom;
         clear_counters  = ($urandom_range(0, 49) == 0);
         sample();
         prev_gnt = bus.lkp_gnt;
      end
      next_cycle();
      bus.lkp_req = 1'b0; bus.tbl_rd_req = 1'b0; bus.tbl_wr_req = 1'b0;
      clear_counters = 1'b0;
      repeat (20) next_cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
